// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared constants and types for the sequential Booth multiplier.
//   MULT_W     : data path width (fixed by the 32-bit carry-lookahead adder)
//   MULT_ITER  : number of Booth iterations per multiply
//   MS_IDLE / MS_RUN / MS_DONE : 2-bit state encodings
//   mult_state_e : FSM state type built on those encodings
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_W    = 32;
    localparam int MULT_ITER = 32;

    localparam logic [1:0] MS_IDLE = 2'd0;
    localparam logic [1:0] MS_RUN  = 2'd1;
    localparam logic [1:0] MS_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = MS_IDLE,
        ST_RUN  = MS_RUN,
        ST_DONE = MS_DONE
    } mult_state_e;

    // Iteration counter value seen during the final RUN cycle.
    localparam logic [4:0] LAST_COUNT = 5'(MULT_ITER - 1);

endpackage

// File: rtl/cla_32bit.sv
// ---------------------------------------------------------------------------
// cla_32bit
// 32-bit carry-lookahead adder built from eight 4-bit groups. Group carries
// are produced by lookahead over group generate/propagate terms; carries
// inside a group are derived from the group carry-in.
//   S   : 32-bit sum
//   c32 : carry out of bit 31
//   a,b : 32-bit operands
//   c0  : carry in
// ---------------------------------------------------------------------------
module cla_32bit (
    output logic [31:0] S,
    output logic        c32,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c0
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] carry;
    logic [8:0]  group_c;
    logic        group_g;
    logic        group_p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        group_c    = '0;
        carry      = '0;
        group_g    = 1'b0;
        group_p    = 1'b0;
        group_c[0] = c0;
        for (int k = 0; k < 8; k++) begin
            group_g = g[4*k+3]
                    | (p[4*k+3] & g[4*k+2])
                    | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                    | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            group_p = &p[4*k +: 4];
            group_c[k+1] = group_g | (group_p & group_c[k]);
        end
        for (int i = 0; i < 32; i++) begin
            if (i % 4 == 0) begin
                carry[i] = group_c[i/4];
            end else begin
                carry[i] = g[i-1] | (p[i-1] & carry[i-1]);
            end
        end
    end

    assign S   = p ^ carry;
    assign c32 = group_c[8];

endmodule

// File: rtl/mult_booth_seq.sv
// ---------------------------------------------------------------------------
// mult_booth_seq
// Sequential 32x32 signed multiplier, radix-2 Booth, one add/subtract pass
// through a single cla_32bit per cycle followed by an arithmetic shift.
// Returns the low 32 bits of the product and a signed-overflow exception.
//   clock     : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   start     : request a multiply (sampled only in IDLE)
//   data_a    : multiplicand, captured with start
//   data_b    : multiplier, captured with start
//   result    : low 32 bits of the product, held until the next accept
//   exception : 64-bit product does not fit in 32 signed bits
//   ready     : one-cycle pulse, result/exception valid
//   busy      : high while iterating
// Build option: MULT_ZERO_BYPASS_EN -- when defined, a zero operand skips
// the iterations and completes one cycle after the accept.
// ---------------------------------------------------------------------------
module mult_booth_seq
    import mult_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [MULT_W-1:0] data_a,
    input  logic [MULT_W-1:0] data_b,
    output logic [MULT_W-1:0] result,
    output logic              exception,
    output logic              ready,
    output logic              busy
);

    mult_state_e         state_q, state_d;
    logic [MULT_W-1:0]   m_q, m_d;
    logic [2*MULT_W:0]   p_q, p_d;
    logic [4:0]          count_q, count_d;
    logic [MULT_W-1:0]   result_q, result_d;
    logic                exception_q, exception_d;

    logic                booth_add;
    logic                booth_sub;
    logic [MULT_W-1:0]   operand;
    logic [MULT_W-1:0]   sum;
    logic                c32;
    logic                s32;
    logic [MULT_W:0]     high_next;
    logic [2*MULT_W:0]   p_step;
    logic                zero_op;

    assign booth_add = (p_q[1:0] == 2'b01);
    assign booth_sub = (p_q[1:0] == 2'b10);
    assign operand   = booth_sub ? ~m_q : m_q;

    cla_32bit u_cla (
        .S   (sum),
        .c32 (c32),
        .a   (p_q[2*MULT_W:MULT_W+1]),
        .b   (operand),
        .c0  (booth_sub)
    );

    // The high half is summed as a 33-bit sign-extended value so that the
    // most negative multiplicand does not overflow the partial product.
    always_comb begin
        s32 = p_q[2*MULT_W] ^ operand[MULT_W-1] ^ c32;
        if (booth_add || booth_sub) begin
            high_next = {s32, sum};
        end else begin
            high_next = {p_q[2*MULT_W], p_q[2*MULT_W:MULT_W+1]};
        end
        p_step = {high_next, p_q[MULT_W:1]};
    end

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_op = (data_a == '0) || (data_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Result and exception are loaded from the final shifted product on the
    // edge that enters DONE, so they are already valid while ready is high.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        p_d         = p_q;
        count_d     = count_q;
        result_d    = result_q;
        exception_d = exception_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d         = data_a;
                    p_d         = {{MULT_W{1'b0}}, data_b, 1'b0};
                    count_d     = '0;
                    result_d    = '0;
                    exception_d = 1'b0;
                    state_d     = zero_op ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                p_d     = p_step;
                count_d = count_q + 5'd1;
                if (count_q == LAST_COUNT) begin
                    state_d     = ST_DONE;
                    result_d    = p_step[MULT_W:1];
                    exception_d = (p_step[2*MULT_W:MULT_W+1] != {MULT_W{p_step[MULT_W]}});
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            m_q         <= '0;
            p_q         <= '0;
            count_q     <= '0;
            result_q    <= '0;
            exception_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            p_q         <= p_d;
            count_q     <= count_d;
            result_q    <= result_d;
            exception_q <= exception_d;
        end
    end

    assign result    = result_q;
    assign exception = exception_q;
    assign ready     = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_mult_booth_seq.sv
// ---------------------------------------------------------------------------
// tb_mult_booth_seq
// Scoreboard bench for mult_booth_seq: the driver pushes the hand-computed
// expectation for each accepted multiply, and a monitor pops and compares
// whenever ready is seen. Honours MULT_ZERO_BYPASS_EN for expected latency.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_booth_seq;

`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] data_a = '0;
    logic [31:0] data_b = '0;
    logic [31:0] result;
    logic        exception;
    logic        ready;
    logic        busy;

    typedef struct {
        logic [31:0] r;
        logic        e;
        int          acc;
        int          lat;
        int          busy_n;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   first_acc = 0;

    mult_booth_seq dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .data_a    (data_a),
        .data_b    (data_b),
        .result    (result),
        .exception (exception),
        .ready     (ready),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Cycle counter, read only on falling edges where it is stable.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("[TB] FAIL %s: bound expired or unexpected event", name);
    endtask

    // Wait for IDLE, raise start for one cycle and, when tracked, push the
    // expected response with the cycle in which the accept happens.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] er, input logic ee,
                                  input bit track, input string name);
        exp_t e;
        int   guard;
        bit   zero;
        guard = 0;
        @(negedge clock);
        while ((busy || ready) && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 100) fail_now({name, "_idle_wait"});
        data_a = a;
        data_b = b;
        start  = 1'b1;
        zero   = (a == 32'h0) || (b == 32'h0);
        if (track) begin
            e.r      = er;
            e.e      = ee;
            e.acc    = cyc;
            e.lat    = (zero && BYPASS) ? 1 : 33;
            e.busy_n = (zero && BYPASS) ? 0 : 32;
            e.name   = name;
            sb_q.push_back(e);
        end
        last_acc = cyc;
        @(negedge clock);
        start = 1'b0;
        check_output({name, "_clr_res"}, result, 32'h0);
        check_output({name, "_clr_exc"}, {31'b0, exception}, 32'h0);
    endtask

    // Monitor: compare every ready pulse against the scoreboard head, and
    // confirm the pulse lasts one cycle and busy covered the iterations.
    initial begin
        exp_t e;
        int   busy_run;
        bit   expect_low;
        busy_run   = 0;
        expect_low = 1'b0;
        forever begin
            @(negedge clock);
            if (expect_low) begin
                check_output("ready_width", {31'b0, ready}, 32'h0);
                expect_low = 1'b0;
            end
            if (ready) begin
                expect_low = 1'b1;
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_ready");
                end else begin
                    e = sb_q.pop_front();
                    check_output({e.name, "_result"}, result, e.r);
                    check_output({e.name, "_exc"}, {31'b0, exception}, {31'b0, e.e});
                    check_output({e.name, "_latency"}, cyc - e.acc, e.lat);
                    check_output({e.name, "_busy_at_ready"}, {31'b0, busy}, 32'h0);
                    check_output({e.name, "_busy_cycles"}, busy_run, e.busy_n);
                end
            end
            busy_run = busy ? busy_run + 1 : 0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    logic [31:0] va [11] = '{32'h00000007, 32'h80000000, 32'h80000000, 32'h00010000,
                             32'h0000FFFF, 32'hFFFFFFFB, 32'h7FFFFFFF, 32'h80000000,
                             32'hFFFFFFFF, 32'hFFFF8000, 32'h00012345};
    logic [31:0] vb [11] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h00000001, 32'h00010000,
                             32'h0000FFFF, 32'hFFFFFFFA, 32'h00000002, 32'h80000000,
                             32'hFFFFFFFF, 32'h00010000, 32'h00000100};
    logic [31:0] vr [11] = '{32'hFFFFFFEB, 32'h80000000, 32'h80000000, 32'h00000000,
                             32'hFFFE0001, 32'h0000001E, 32'hFFFFFFFE, 32'h00000000,
                             32'h00000001, 32'h80000000, 32'h01234500};
    logic        ve [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int guard;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_output("rst_result", result, 32'h0);
        check_output("rst_exc", {31'b0, exception}, 32'h0);
        check_output("rst_ready", {31'b0, ready}, 32'h0);
        check_output("rst_busy", {31'b0, busy}, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(va[i], vb[i], vr[i], ve[i], 1'b1, $sformatf("vec%0d", i));
        end

        // A start pulse during RUN must be ignored; the next accept lands
        // exactly 34 cycles after the first.
        apply_stimulus(32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b1, "ign_a");
        first_acc = last_acc;
        repeat (9) @(negedge clock);
        data_a = 32'h00000005;
        data_b = 32'h00000005;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        apply_stimulus(32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b1, 1'b1, "ign_b");
        check_output("accept_gap", last_acc - first_acc, 34);

        // Asynchronous reset mid-operation: outputs drop at once and the
        // aborted multiply never produces a ready pulse.
        apply_stimulus(32'h00012345, 32'h00000100, 32'h01234500, 1'b0, 1'b0, "aborted");
        repeat (13) @(negedge clock);
        check_output("busy_before_reset", {31'b0, busy}, 32'h1);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_rst_busy", {31'b0, busy}, 32'h0);
        check_output("async_rst_ready", {31'b0, ready}, 32'h0);
        check_output("async_rst_result", result, 32'h0);
        check_output("async_rst_exc", {31'b0, exception}, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        apply_stimulus(32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0000001E, 1'b0, 1'b1, "after_reset");

        // Zero operands: latency depends on the bypass build option.
        apply_stimulus(32'h00000000, 32'h12345678, 32'h0, 1'b0, 1'b1, "zero_a");
        apply_stimulus(32'h12345678, 32'h00000000, 32'h0, 1'b0, 1'b1, "zero_b");
        apply_stimulus(32'h00000000, 32'h00000000, 32'h0, 1'b0, 1'b1, "zero_ab");

        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (sb_q.size() != 0) fail_now("drain_timeout");
        repeat (3) @(negedge clock);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mult_booth_seq.md
# mult_booth_seq

Sequential 32×32 signed multiplier for the processor's multdiv unit, using radix-2 Booth recoding. Each iteration makes one add or subtract pass through a single instance of the 32-bit carry-lookahead adder (`cla_32bit`), then an arithmetic right shift. It returns the low 32 bits of the product and an overflow exception, with a one-cycle `ready` pulse back to the pipeline stall logic.

## Interface
- No parameters: width is fixed at 32 by the adder it drives.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a multiply; sampled only in IDLE
- data_a  in  32  multiplicand, two's complement, sampled with start
- data_b  in  32  multiplier, two's complement, sampled with start
- result  out  32  low 32 bits of data_a×data_b; holds its value until the next accepted start
- exception  out  1  signed overflow: the 64-bit product does not fit in 32 bits; same validity as result
- ready  out  1  one-cycle pulse: result and exception are valid
- busy  out  1  high from the cycle after an accepted start until the cycle ready is asserted

## Operation
- FSM states: IDLE, RUN, DONE.
    - IDLE→RUN when start=1.
    - RUN→DONE after the 32nd iteration.
    - DONE→IDLE unconditionally.
- Accept (IDLE, start=1):
    - M ← data_a.
    - Product register P[64:0] ← {32'b0, data_b, 1'b0}.
    - Iteration count ← 0.
    - result and exception are cleared to 0.
- Each RUN cycle reads Booth pair {P[1], P[0]}:
    - 00 or 11: no change to the high half.
    - 01: high half ← P[64:33] + M through `cla_32bit`, c0=0.
    - 10: high half ← P[64:33] + ~M through `cla_32bit`, c0=1.
- 33rd-bit rule:
    - The sum is treated as 33-bit sign-extended.
    - Sign bit s32 = P[64] ^ operand[31] ^ c32, where operand is M or ~M.
    - On the 00/11 no-op, s32 = P[64].
    - This makes M = −2^31 correct.
- After the add step, P is arithmetic-shifted right by 1, with s32 shifted into P[64].
- Count increments every RUN cycle; the exit happens when count = 31 at the clock edge.
- DONE:
    - result ← P[32:1].
    - exception ← 1 unless P[64:33] equals 32 copies of P[32].
    - ready=1 and busy=0 in this state.
- start in RUN or DONE is ignored; the operation is not restarted and no operands are re-captured.
- Reset (async, any state):
    - State returns to IDLE.
    - result, exception, ready and busy all go to 0.
    - P and count are cleared.
    - Any in-flight operation is discarded and produces no ready pulse.

## Timing
- start is accepted at edge T.
- RUN occupies cycles T+1 through T+32.
- ready=1 during cycle T+33; result and exception are registered outputs, valid from T+33 onward.
- A new start may be accepted in cycle T+34, which is IDLE again. Throughput is one multiply per 34 cycles.
- The adder is combinational inside a single cycle; there is no pipelining of the add.

## Configuration
- `MULT_ZERO_BYPASS_EN`
    - Defined: an accepted start with data_a==0 or data_b==0 goes IDLE→DONE directly. result=0, exception=0, and ready=1 in cycle T+1.
    - Undefined: every operation takes the full 34-cycle path.
    - Nonzero operands behave identically either way.

## Structure
- Shared package `mult_pkg` holds:
    - State encoding constants MS_IDLE, MS_RUN, MS_DONE (2-bit).
    - MULT_W=32.
    - MULT_ITER=32.
- Sub-module: one instance of the existing `cla_32bit` (S, c32, a, b, c0) is the only adder. No second adder and no behavioural `+` on the 32-bit data path.
- Count register: 5 bits. A shared counter module is not needed.

## Test plan
- 7 × −3 → at T+33: result=0xFFFFFFEB, exception=0, ready high for exactly 1 cycle, busy high T+1..T+32.
- 0x80000000 × 0xFFFFFFFF (−2^31 × −1) → result=0x80000000, exception=1; with 0x80000000 × 1 → result=0x80000000, exception=0.
- 0x00010000 × 0x00010000 → result=0x00000000, exception=1; 0x0000FFFF × 0x0000FFFF → 0xFFFE0001, exception=1.
- start pulsed again at T+10 with different operands → ignored; the original product appears at T+33 and the next accept is possible at T+34.
- reset_n asserted low at T+15 (asynchronously, mid-cycle) → outputs 0 immediately; no ready pulse; a fresh start after release gives the correct result 34 cycles later.
- 0 × 0x12345678 → result=0, exception=0, ready at T+1 with `MULT_ZERO_BYPASS_EN` defined and at T+33 without it.
